// File: rtl/pipeline_types.sv
// Shared pipeline types for the reorder buffer: depth, tag width and the ROB entry record.
package pipeline_types;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned ROB_TAG_W = $clog2(ROB_DEPTH);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [4:0]  rd_log;
    logic [5:0]  rd_phys;
    logic [5:0]  rd_old_phys;
    logic        is_branch;
    logic        mispredicted;
    logic [31:0] pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping ring pointer with increment and synchronous clear; used for ROB head and tail.
module rob_ptr #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] ptr_o
);

  logic [Width-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order completion tracker: allocate at tail, complete from CDB, retire/flush from head.
// Define ROB_PERF_CNT_EN to add retired-instruction and flush performance counters.
module reorder_buffer
  import pipeline_types::*;
#(
  parameter int unsigned DEPTH = ROB_DEPTH,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rob_push_i,
  input  rob_entry_t       rob_entry_i,
  output logic             rob_full_o,
  output logic [TAG_W-1:0] rob_alloc_tag_o,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic             cdb_mispredict_i,
  output logic             commit_valid_o,
  output logic [5:0]       commit_rd_phys_o,
  output logic [5:0]       commit_rd_old_phys_o,
  output logic [31:0]      commit_pc_o,
  output logic             commit_is_branch_o,
`ifdef ROB_PERF_CNT_EN
  output logic [31:0]      perf_retired_o,
  output logic [31:0]      perf_flush_o,
`endif
  output logic             flush_o
);

  localparam int unsigned CntW = TAG_W + 1;

  rob_entry_t       entries_d [DEPTH];
  rob_entry_t       entries_q [DEPTH];
  logic [CntW-1:0]  count_d, count_q;
  logic [TAG_W-1:0] head, tail;
  rob_entry_t       head_e;
  logic             push_fire;
  logic             unused_rd_log;

  rob_ptr #(.Width(TAG_W)) u_head_ptr (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (commit_valid_o),
    .clr_i (flush_o),
    .ptr_o (head)
  );

  rob_ptr #(.Width(TAG_W)) u_tail_ptr (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (push_fire),
    .clr_i (flush_o),
    .ptr_o (tail)
  );

  // Full comes only from the registered count, so a same-cycle retire never admits a push.
  assign rob_full_o      = (count_q == CntW'(DEPTH));
  assign rob_alloc_tag_o = tail;
  assign push_fire       = rob_push_i && !rob_full_o && !flush_o;

  assign head_e               = entries_q[head];
  assign commit_valid_o       = head_e.valid && head_e.done;
  assign flush_o              = commit_valid_o && head_e.mispredicted;
  assign commit_rd_phys_o     = head_e.rd_phys;
  assign commit_rd_old_phys_o = head_e.rd_old_phys;
  assign commit_pc_o          = head_e.pc;
  assign commit_is_branch_o   = head_e.is_branch;
  assign unused_rd_log        = ^head_e.rd_log;

  always_comb begin
    entries_d = entries_q;
    if (flush_o) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
      end
    end else begin
      if (push_fire) begin
        entries_d[tail]              = rob_entry_i;
        entries_d[tail].valid        = 1'b1;
        entries_d[tail].done         = 1'b0;
        entries_d[tail].mispredicted = 1'b0;
      end
      if (cdb_valid_i && entries_q[cdb_tag_i].valid) begin
        entries_d[cdb_tag_i].done         = 1'b1;
        entries_d[cdb_tag_i].mispredicted = cdb_mispredict_i;
      end
      if (commit_valid_o) begin
        entries_d[head].valid = 1'b0;
      end
    end
  end

  always_comb begin
    count_d = count_q + CntW'(push_fire) - CntW'(commit_valid_o);
    if (flush_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_retired_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired_q <= '0;
      perf_flush_q   <= '0;
    end else begin
      perf_retired_q <= perf_retired_q + 32'(commit_valid_o);
      perf_flush_q   <= perf_flush_q + 32'(flush_o);
    end
  end

  assign perf_retired_o = perf_retired_q;
  assign perf_flush_o   = perf_flush_q;
`endif

  push_while_full: assert property (@(posedge clk) disable iff (rst)
    !(rob_push_i && rob_full_o))
    else $warning("rob push while full was dropped");

endmodule
